control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Multi-cycle FSM controller for the 8-bit accumulator processor. Drives every
//  load/clear/select strobe of the datapath from the 4-bit opcode and the ACC==0 flag.
//  Together with the datapath it forms the complete Fibonacci CPU.
//  Per instruction: FETCH -> DECODE -> EXEC (plus optional RAM wait) -> FETCH.
// PARAMETERS
//  MEM_WAIT  default 0  extra EXEC cycles for RAM-read ops (LDA/ADD/SUB/AND/OR), 0..15
// PORTS
//  clk                 in   1  rising-edge clock
//  rst                 in   1  synchronous, active-high reset
//  opcode              in   4  IR[11:8] from datapath
//  acc_eq_zero_signal  in   1  1 when ACC==0
//  pc_ld, pc_clr       out  1  PC load / clear
//  pc_scr              out  1  PC source: 0=PC+1, 1=IR[7:0]
//  ir_ld, ir_clr       out  1  IR load / clear
//  acc_ld, acc_clr     out  1  ACC load / clear
//  acc_scr             out  2  ACC source: 00=ALU, 01=RAM, 10=IR[7:0], 11=data_in
//  alu_op              out  2  00=ADD, 01=SUB, 10=AND, 11=OR
//  rout_ld, rout_clr   out  1  output register load / clear
//  wr_en               out  1  RAM write strobe, addr=IR[7:0], data=ACC
//  halted              out  1  1 while in HALT
// BEHAVIOUR
//  States: INIT, FETCH, DECODE, EXEC, WAIT, HALT; Moore outputs decoded from state+opcode.
//  Any strobe not listed for a state is 0; alu_op/acc_scr/pc_scr are 0 unless listed.
//  rst=1 -> next state INIT regardless of current state (mid-instruction too); no strobe
//   other than clears is issued in the cycle after rst.
//  INIT: pc_clr=ir_clr=acc_clr=rout_clr=1; -> FETCH. Only state with clears asserted.
//  FETCH: ir_ld=1, pc_ld=1, pc_scr=0 (IR<=ROM[PC], PC<=PC+1 on same edge); -> DECODE.
//  DECODE: no strobes (IR settles); -> EXEC, or -> WAIT for RAM-read ops when MEM_WAIT>0.
//  WAIT: down-counter loaded with MEM_WAIT at DECODE exit; -> EXEC when count reaches 1.
//  EXEC (one cycle, -> FETCH unless noted):
//   0x0 NOP  none
//   0x1 LDA  acc_ld, acc_scr=01
//   0x2 STA  wr_en
//   0x3 ADD  acc_ld, acc_scr=00, alu_op=00
//   0x4 SUB  acc_ld, acc_scr=00, alu_op=01 (mod 256, borrow discarded)
//   0x5 AND  acc_ld, acc_scr=00, alu_op=10
//   0x6 OR   acc_ld, acc_scr=00, alu_op=11
//   0x7 LDI  acc_ld, acc_scr=10
//   0x8 IN   acc_ld, acc_scr=11
//   0x9 OUT  rout_ld
//   0xA JMP  pc_ld, pc_scr=1
//   0xB JZ   pc_ld, pc_scr=1 only if acc_eq_zero_signal=1
//   0xC JNZ  pc_ld, pc_scr=1 only if acc_eq_zero_signal=0
//   0xF HLT  -> HALT
//   0xD,0xE  illegal (see CONFIGURATION)
//  HALT: all strobes 0, halted=1; only rst exits.
//  Flag sampled combinationally in EXEC: reflects ACC after previous instruction's edge.
//  PC wrap: 0xFF+1 -> 0x00 (datapath adder); controller takes no action.
//  CPI: 3 cycles; RAM-read ops 3+MEM_WAIT; HLT enters HALT after 3.
// CONFIGURATION
//  ILLEGAL_OP_TRAP_EN defined: 0xD/0xE in EXEC -> HALT; adds output port
//   illegal_op (1 bit, 1 in HALT reached via illegal opcode, cleared only by rst).
//  Not defined: 0xD/0xE execute as NOP; no illegal_op port.
// TESTING
//  rst held 2 cycles then released -> 1 cycle all clears=1, then FETCH with ir_ld=pc_ld=1, pc_scr=0.
//  Program LDI 0x05; STA 0x10; ADD 0x10; OUT -> rout_ld in 12th cycle after INIT; ADD EXEC alu_op=00, acc_scr=00.
//  JZ 0x20 with flag=0 -> no pc_ld in EXEC; same with flag=1 -> pc_ld=1, pc_scr=1.
//  MEM_WAIT=2, LDA 0x03 -> FETCH,DECODE,WAIT,WAIT,EXEC(acc_ld, acc_scr=01); 5 cycles.
//  HLT -> halted=1 for 50 cycles, no strobes; rst pulse -> INIT then FETCH.
//  Opcode 0xD: with ILLEGAL_OP_TRAP_EN -> halted=1, illegal_op=1; without -> FETCH next, no strobes.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multi-cycle FSM controller for the 8-bit accumulator CPU.
//
// Each instruction runs FETCH -> DECODE -> (WAIT x MEM_WAIT for RAM-read ops)
// -> EXEC -> FETCH. HLT parks the machine in HALT until rst.
//
// Outputs are Moore-style: they are decoded from the current state register
// and the opcode that the datapath's IR presents. The opcode only changes on
// the FETCH edge, so it is stable throughout DECODE, WAIT and EXEC.
//
// Optional feature, selected by the macro ILLEGAL_OP_TRAP_EN:
//   defined     - opcodes 0xD/0xE trap into HALT, and the extra output
//                 illegal_op flags that the halt was caused by a bad opcode.
//   not defined - opcodes 0xD/0xE behave as NOP and illegal_op does not exist.
module control_unit #(
    // Extra EXEC latency for RAM-read ops (LDA/ADD/SUB/AND/OR), 0..15
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       acc_eq_zero_signal,
    output logic       pc_ld,
    output logic       pc_clr,
    output logic       pc_scr,
    output logic       ir_ld,
    output logic       ir_clr,
    output logic       acc_ld,
    output logic       acc_clr,
    output logic [1:0] acc_scr,
    output logic [1:0] alu_op,
    output logic       rout_ld,
    output logic       rout_clr,
    output logic       wr_en,
    output logic       halted
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_IN  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JNZ = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ACC source select and ALU function codes
    localparam logic [1:0] ACC_SRC_ALU = 2'b00;
    localparam logic [1:0] ACC_SRC_RAM = 2'b01;
    localparam logic [1:0] ACC_SRC_IMM = 2'b10;
    localparam logic [1:0] ACC_SRC_IN  = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Wait-state configuration; a zero MEM_WAIT removes the WAIT state
    // from every path.
    localparam logic [3:0] WAIT_LOAD = MEM_WAIT[3:0];
    localparam bit         HAS_WAIT  = (MEM_WAIT != 0);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0] state_reg, state_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;

    // Ops that read RAM need the extra read latency before EXEC.
    logic ram_read;
    assign ram_read = (opcode == OP_LDA) || (opcode == OP_ADD) ||
                      (opcode == OP_SUB) || (opcode == OP_AND) ||
                      (opcode == OP_OR);

    // Ops that end the instruction stream and park the machine in HALT.
    logic stop_op;
`ifdef ILLEGAL_OP_TRAP_EN
    logic bad_op;
    assign bad_op  = (opcode == 4'hD) || (opcode == 4'hE);
    assign stop_op = (opcode == OP_HLT) || bad_op;
`else
    assign stop_op = (opcode == OP_HLT);
`endif

    // State and wait counter; rst forces INIT from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_INIT;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next-state logic and wait down-counter.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (HAS_WAIT && ram_read) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = WAIT_LOAD;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_WAIT: begin
                // Leave on the cycle the count reads 1, so the number of
                // WAIT cycles equals the loaded value.
                if (wait_cnt_reg <= 4'd1) begin
                    state_next    = ST_EXEC;
                    wait_cnt_next = 4'd0;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_EXEC: begin
                if (stop_op) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_reg;

    // Sticky record that HALT was entered through an illegal opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_reg <= 1'b0;
        end else if ((state_reg == ST_EXEC) && bad_op) begin
            illegal_reg <= 1'b1;
        end
    end

    assign illegal_op = illegal_reg;
`endif

    // Strobe decode from state and opcode; anything not set stays 0.
    always_comb begin
        pc_ld    = 1'b0;
        pc_clr   = 1'b0;
        pc_scr   = 1'b0;
        ir_ld    = 1'b0;
        ir_clr   = 1'b0;
        acc_ld   = 1'b0;
        acc_clr  = 1'b0;
        acc_scr  = ACC_SRC_ALU;
        alu_op   = ALU_ADD;
        rout_ld  = 1'b0;
        rout_clr = 1'b0;
        wr_en    = 1'b0;
        halted   = 1'b0;
        case (state_reg)
            ST_INIT: begin
                // The only place the datapath is cleared.
                pc_clr   = 1'b1;
                ir_clr   = 1'b1;
                acc_clr  = 1'b1;
                rout_clr = 1'b1;
            end
            ST_FETCH: begin
                // IR <= ROM[PC] and PC <= PC+1 on the same edge.
                ir_ld  = 1'b1;
                pc_ld  = 1'b1;
                pc_scr = 1'b0;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LDA: begin
                        acc_ld  = 1'b1;
                        acc_scr = ACC_SRC_RAM;
                    end
                    OP_STA: begin
                        wr_en = 1'b1;
                    end
                    OP_ADD: begin
                        acc_ld  = 1'b1;
                        acc_scr = ACC_SRC_ALU;
                        alu_op  = ALU_ADD;
                    end
                    OP_SUB: begin
                        acc_ld  = 1'b1;
                        acc_scr = ACC_SRC_ALU;
                        alu_op  = ALU_SUB;
                    end
                    OP_AND: begin
                        acc_ld  = 1'b1;
                        acc_scr = ACC_SRC_ALU;
                        alu_op  = ALU_AND;
                    end
                    OP_OR: begin
                        acc_ld  = 1'b1;
                        acc_scr = ACC_SRC_ALU;
                        alu_op  = ALU_OR;
                    end
                    OP_LDI: begin
                        acc_ld  = 1'b1;
                        acc_scr = ACC_SRC_IMM;
                    end
                    OP_IN: begin
                        acc_ld  = 1'b1;
                        acc_scr = ACC_SRC_IN;
                    end
                    OP_OUT: begin
                        rout_ld = 1'b1;
                    end
                    OP_JMP: begin
                        pc_ld  = 1'b1;
                        pc_scr = 1'b1;
                    end
                    OP_JZ: begin
                        // Flag reflects ACC as left by the previous instruction.
                        if (acc_eq_zero_signal) begin
                            pc_ld  = 1'b1;
                            pc_scr = 1'b1;
                        end
                    end
                    OP_JNZ: begin
                        if (!acc_eq_zero_signal) begin
                            pc_ld  = 1'b1;
                            pc_scr = 1'b1;
                        end
                    end
                    // NOP, HLT and 0xD/0xE issue no strobes in EXEC.
                    default: begin
                        pc_ld = 1'b0;
                    end
                endcase
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            // DECODE and WAIT are strobe-free.
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule
